corriente_rampa: RTL and testbench

//  Current-level sequencer that drives the 4-bit Corriente code into the

---
 rtl/corriente_rampa.sv | 135 +++++++++++++
 tb/tb_corriente_rampa.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/corriente_rampa.sv
// Current-level sequencer: walks Corriente one step per PASO_CICLOS clocks toward the
// button-set target, with immediate shutdown on fault or disable.
module corriente_rampa #(
    parameter int unsigned PASO_CICLOS = 25000000,
    parameter int unsigned MAX_NIVEL   = 10,
    parameter int unsigned ANCHO_CNT   = 25
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Boton_Subir,
    input  logic       Boton_Bajar,
    input  logic       Habilitar,
    input  logic       Falla,
    input  logic       Borrar_Falla,
    output logic [3:0] Corriente,
    output logic [3:0] Objetivo,
    output logic       Rampa_Activa,
    output logic       Falla_Activa
);

    localparam logic [3:0]           NivelMax = 4'(MAX_NIVEL);
    localparam logic [ANCHO_CNT-1:0] CntFin   = ANCHO_CNT'(PASO_CICLOS - 1);

    typedef enum logic [1:0] {StReposo, StSubir, StBajar, StFalla} estado_e;

    estado_e              estado_q;
    estado_e              estado_nuevo;
    logic [ANCHO_CNT-1:0] cnt_q;
    logic [ANCHO_CNT-1:0] cnt_nuevo;
    logic [3:0]           corr_nueva;
    logic [3:0]           obj_nuevo;
    logic [1:0]           subir_sync_q;
    logic [1:0]           bajar_sync_q;
    logic                 subir_prev_q;
    logic                 bajar_prev_q;
    logic                 pulso_subir;
    logic                 pulso_bajar;

    // Raw buttons: two-flop synchronizer followed by a rising-edge detector.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            subir_sync_q <= '0;
            bajar_sync_q <= '0;
            subir_prev_q <= 1'b0;
            bajar_prev_q <= 1'b0;
        end else begin
            subir_sync_q <= {subir_sync_q[0], Boton_Subir};
            bajar_sync_q <= {bajar_sync_q[0], Boton_Bajar};
            subir_prev_q <= subir_sync_q[1];
            bajar_prev_q <= bajar_sync_q[1];
        end
    end

    assign pulso_subir = subir_sync_q[1] & ~subir_prev_q;
    assign pulso_bajar = bajar_sync_q[1] & ~bajar_prev_q;

    always_comb begin
        obj_nuevo = Objetivo;
        if (pulso_subir && !pulso_bajar && (Objetivo < NivelMax)) begin
            obj_nuevo = Objetivo + 4'd1;
        end else if (pulso_bajar && !pulso_subir && (Objetivo != 4'd0)) begin
            obj_nuevo = Objetivo - 4'd1;
        end
    end

    // Stepping is judged against the updated target so a step never overshoots it.
    always_comb begin
        corr_nueva = Corriente;
        cnt_nuevo  = '0;
        case (estado_q)
            StSubir: begin
                if (cnt_q == CntFin) begin
                    if (Corriente < obj_nuevo) corr_nueva = Corriente + 4'd1;
                end else begin
                    cnt_nuevo = cnt_q + 1'b1;
                end
            end
            StBajar: begin
                if (cnt_q == CntFin) begin
                    if (Corriente > obj_nuevo) corr_nueva = Corriente - 4'd1;
                end else begin
                    cnt_nuevo = cnt_q + 1'b1;
                end
            end
            default: cnt_nuevo = '0;
        endcase

        if (corr_nueva < obj_nuevo) begin
            estado_nuevo = StSubir;
        end else if (corr_nueva > obj_nuevo) begin
            estado_nuevo = StBajar;
        end else begin
            estado_nuevo = StReposo;
        end

        // Reversal or arrival restarts the dwell; same-direction retargeting keeps it.
        if (estado_nuevo != estado_q) cnt_nuevo = '0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q     <= StReposo;
            cnt_q        <= '0;
            Corriente    <= 4'd0;
            Objetivo     <= 4'd0;
            Rampa_Activa <= 1'b0;
            Falla_Activa <= 1'b0;
        end else if (Falla) begin
            estado_q     <= StFalla;
            cnt_q        <= '0;
            Corriente    <= 4'd0;
            Objetivo     <= 4'd0;
            Rampa_Activa <= 1'b0;
            Falla_Activa <= 1'b1;
        end else if (estado_q == StFalla) begin
            if (Borrar_Falla) begin
                estado_q     <= StReposo;
                Falla_Activa <= 1'b0;
            end
        end else if (!Habilitar) begin
            estado_q     <= StReposo;
            cnt_q        <= '0;
            Corriente    <= 4'd0;
            Objetivo     <= obj_nuevo;
            Rampa_Activa <= 1'b0;
        end else begin
            estado_q     <= estado_nuevo;
            cnt_q        <= cnt_nuevo;
            Corriente    <= corr_nueva;
            Objetivo     <= obj_nuevo;
            Rampa_Activa <= (estado_nuevo != StReposo);
        end
    end

endmodule

// File: tb/tb_corriente_rampa.sv
// Directed bench for corriente_rampa with PASO_CICLOS=4, MAX_NIVEL=10; expected
// cycle positions are worked out by hand from the button-to-target latency.
module tb_corriente_rampa;

    logic       Clock;
    logic       Reset;
    logic       Boton_Subir;
    logic       Boton_Bajar;
    logic       Habilitar;
    logic       Falla;
    logic       Borrar_Falla;
    logic [3:0] Corriente;
    logic [3:0] Objetivo;
    logic       Rampa_Activa;
    logic       Falla_Activa;

    int checks = 0;
    int errors = 0;
    bit ok;

    corriente_rampa #(
        .PASO_CICLOS(4),
        .MAX_NIVEL  (10),
        .ANCHO_CNT  (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Boton_Subir (Boton_Subir),
        .Boton_Bajar (Boton_Bajar),
        .Habilitar   (Habilitar),
        .Falla       (Falla),
        .Borrar_Falla(Borrar_Falla),
        .Corriente   (Corriente),
        .Objetivo    (Objetivo),
        .Rampa_Activa(Rampa_Activa),
        .Falla_Activa(Falla_Activa)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task tick();
        @(posedge Clock);
        #1;
    endtask

    // Target moves on the edge right after each press returns.
    task press_up();
        Boton_Subir = 1'b1; tick();
        Boton_Subir = 1'b0; tick();
    endtask

    task press_down();
        Boton_Bajar = 1'b1; tick();
        Boton_Bajar = 1'b0; tick();
    endtask

    task wait_corr(input logic [3:0] nivel, input bit quieto, input int limite, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < limite; i++) begin
            tick();
            if (Corriente == nivel && (!quieto || !Rampa_Activa)) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task test_reset();
        Reset = 1'b0; Boton_Subir = 1'b0; Boton_Bajar = 1'b0;
        Habilitar = 1'b0; Falla = 1'b0; Borrar_Falla = 1'b0;
        tick(); tick();
        checks++; if (Corriente !== 4'd0) begin errors++; $display("FAIL reset_corriente got %0d want 0", Corriente); end
        checks++; if (Objetivo !== 4'd0) begin errors++; $display("FAIL reset_objetivo got %0d want 0", Objetivo); end
        checks++; if (Rampa_Activa !== 1'b0) begin errors++; $display("FAIL reset_rampa got %b want 0", Rampa_Activa); end
        checks++; if (Falla_Activa !== 1'b0) begin errors++; $display("FAIL reset_falla got %b want 0", Falla_Activa); end
        Reset = 1'b1; Habilitar = 1'b1;
        tick();
        checks++; if (Corriente !== 4'd0 || Rampa_Activa !== 1'b0) begin errors++; $display("FAIL post_reset got c=%0d r=%b want c=0 r=0", Corriente, Rampa_Activa); end
    endtask

    task test_ramp_up();
        press_up(); press_up(); press_up();
        tick();
        checks++; if (Objetivo !== 4'd3) begin errors++; $display("FAIL ramp_objetivo got %0d want 3", Objetivo); end
        checks++; if (Corriente !== 4'd1 || Rampa_Activa !== 1'b1) begin errors++; $display("FAIL ramp_step1 got c=%0d r=%b want c=1 r=1", Corriente, Rampa_Activa); end
        repeat (3) tick();
        checks++; if (Corriente !== 4'd1) begin errors++; $display("FAIL ramp_dwell got %0d want 1", Corriente); end
        tick();
        checks++; if (Corriente !== 4'd2) begin errors++; $display("FAIL ramp_step2 got %0d want 2", Corriente); end
        repeat (4) tick();
        checks++; if (Corriente !== 4'd3 || Rampa_Activa !== 1'b0) begin errors++; $display("FAIL ramp_done got c=%0d r=%b want c=3 r=0", Corriente, Rampa_Activa); end
    endtask

    task test_saturation();
        repeat (12) press_up();
        tick();
        checks++; if (Objetivo !== 4'd10) begin errors++; $display("FAIL sat_up got %0d want 10", Objetivo); end
        press_down();
        tick();
        Boton_Subir = 1'b1;
        repeat (100) tick();
        Boton_Subir = 1'b0;
        repeat (3) tick();
        checks++; if (Objetivo !== 4'd10) begin errors++; $display("FAIL hold_single_step got %0d want 10", Objetivo); end
        wait_corr(4'd10, 1'b1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_corriente got %0d want 10", Corriente); end
        repeat (12) press_down();
        tick();
        checks++; if (Objetivo !== 4'd0) begin errors++; $display("FAIL sat_down got %0d want 0", Objetivo); end
        wait_corr(4'd0, 1'b1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_down got %0d want 0", Corriente); end
    endtask

    task test_reversal();
        repeat (8) press_up();
        wait_corr(4'd4, 1'b0, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rev_reach4 got %0d want 4", Corriente); end
        repeat (4) press_down();
        checks++; if (Corriente !== 4'd5 || Objetivo !== 4'd5 || Rampa_Activa !== 1'b0) begin
            errors++; $display("FAIL rev_meet got c=%0d o=%0d r=%b want c=5 o=5 r=0", Corriente, Objetivo, Rampa_Activa);
        end
        tick();
        checks++; if (Objetivo !== 4'd4 || Corriente !== 4'd5 || Rampa_Activa !== 1'b1) begin
            errors++; $display("FAIL rev_edge got c=%0d o=%0d r=%b want c=5 o=4 r=1", Corriente, Objetivo, Rampa_Activa);
        end
        repeat (3) tick();
        checks++; if (Corriente !== 4'd5) begin errors++; $display("FAIL rev_dwell got %0d want 5", Corriente); end
        tick();
        checks++; if (Corriente !== 4'd4 || Rampa_Activa !== 1'b0) begin errors++; $display("FAIL rev_step got c=%0d r=%b want c=4 r=0", Corriente, Rampa_Activa); end
    endtask

    task test_fault();
        repeat (3) press_up();
        wait_corr(4'd7, 1'b1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fault_reach7 got %0d want 7", Corriente); end
        Falla = 1'b1;
        tick();
        checks++; if (Corriente !== 4'd0 || Objetivo !== 4'd0 || Falla_Activa !== 1'b1 || Rampa_Activa !== 1'b0) begin
            errors++; $display("FAIL fault_entry got c=%0d o=%0d f=%b r=%b want 0 0 1 0", Corriente, Objetivo, Falla_Activa, Rampa_Activa);
        end
        Borrar_Falla = 1'b1;
        tick();
        checks++; if (Falla_Activa !== 1'b1) begin errors++; $display("FAIL clear_while_fault got %b want 1", Falla_Activa); end
        Falla = 1'b0; Borrar_Falla = 1'b0;
        press_up();
        repeat (3) tick();
        checks++; if (Falla_Activa !== 1'b1 || Objetivo !== 4'd0) begin
            errors++; $display("FAIL fault_hold got f=%b o=%0d want f=1 o=0", Falla_Activa, Objetivo);
        end
        Borrar_Falla = 1'b1;
        tick();
        Borrar_Falla = 1'b0;
        checks++; if (Falla_Activa !== 1'b0 || Corriente !== 4'd0 || Objetivo !== 4'd0) begin
            errors++; $display("FAIL fault_clear got f=%b c=%0d o=%0d want 0 0 0", Falla_Activa, Corriente, Objetivo);
        end
    endtask

    task test_habilitar();
        repeat (6) press_up();
        wait_corr(4'd6, 1'b1, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hab_reach6 got %0d want 6", Corriente); end
        Habilitar = 1'b0;
        tick();
        checks++; if (Corriente !== 4'd0 || Objetivo !== 4'd6 || Rampa_Activa !== 1'b0) begin
            errors++; $display("FAIL hab_off got c=%0d o=%0d r=%b want c=0 o=6 r=0", Corriente, Objetivo, Rampa_Activa);
        end
        press_up();
        tick();
        checks++; if (Objetivo !== 4'd7 || Corriente !== 4'd0) begin errors++; $display("FAIL hab_off_button got o=%0d c=%0d want o=7 c=0", Objetivo, Corriente); end
        press_down();
        tick();
        Habilitar = 1'b1;
        tick();
        checks++; if (Objetivo !== 4'd6 || Corriente !== 4'd0 || Rampa_Activa !== 1'b1) begin
            errors++; $display("FAIL hab_on got o=%0d c=%0d r=%b want o=6 c=0 r=1", Objetivo, Corriente, Rampa_Activa);
        end
        repeat (23) tick();
        checks++; if (Corriente !== 4'd5) begin errors++; $display("FAIL soft_start_23 got %0d want 5", Corriente); end
        tick();
        checks++; if (Corriente !== 4'd6 || Rampa_Activa !== 1'b0) begin errors++; $display("FAIL soft_start_24 got c=%0d r=%b want c=6 r=0", Corriente, Rampa_Activa); end
    endtask

    task test_simultaneous_and_reset();
        Boton_Subir = 1'b1; Boton_Bajar = 1'b1;
        tick();
        Boton_Subir = 1'b0; Boton_Bajar = 1'b0;
        repeat (4) tick();
        checks++; if (Objetivo !== 4'd6 || Rampa_Activa !== 1'b0) begin errors++; $display("FAIL both_buttons got o=%0d r=%b want o=6 r=0", Objetivo, Rampa_Activa); end
        press_up(); press_up();
        repeat (3) tick();
        checks++; if (Rampa_Activa !== 1'b1 || Corriente !== 4'd7) begin errors++; $display("FAIL mid_ramp got c=%0d r=%b want c=7 r=1", Corriente, Rampa_Activa); end
        Reset = 1'b0;
        #2;
        checks++; if (Corriente !== 4'd0 || Objetivo !== 4'd0 || Rampa_Activa !== 1'b0 || Falla_Activa !== 1'b0) begin
            errors++; $display("FAIL async_reset got c=%0d o=%0d r=%b f=%b want all 0", Corriente, Objetivo, Rampa_Activa, Falla_Activa);
        end
        tick();
        Reset = 1'b1;
        repeat (6) tick();
        checks++; if (Corriente !== 4'd0 || Objetivo !== 4'd0 || Rampa_Activa !== 1'b0) begin
            errors++; $display("FAIL after_reset got c=%0d o=%0d r=%b want 0 0 0", Corriente, Objetivo, Rampa_Activa);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_saturation();
        test_reversal();
        test_fault();
        test_habilitar();
        test_simultaneous_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
